// File: rtl/uart_pkg.sv
// Constants shared by the UART command arbiter and the UART controller:
// default widths, the write-flag bit position and the arbiter FSM state codes.
package uart_pkg;

    localparam int unsigned UART_CMD_WIDTH  = 16;
    localparam int unsigned UART_READ_WIDTH = 8;
    localparam int unsigned CMD_WR_BIT      = UART_CMD_WIDTH - 1;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;
    localparam logic [1:0] RESP      = 2'd3;

endpackage

// File: rtl/uart_cmd_arbiter_if.sv
// Requester-side and UART-side signals of the shared UART command arbiter.
// The arbiter takes the slave modport; the system/UART environment takes master.
interface uart_cmd_arbiter_if
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned CMD_WIDTH  = UART_CMD_WIDTH,
    parameter int unsigned READ_WIDTH = UART_READ_WIDTH
);
    localparam int unsigned ID_W = $clog2(N_REQ);

    logic [N_REQ*CMD_WIDTH-1:0] req_cmd;
    logic [N_REQ-1:0]           req_vld;
    logic [N_REQ-1:0]           req_rdy;
    logic [N_REQ-1:0]           rsp_vld;
    logic [READ_WIDTH-1:0]      rsp_data;
    logic                       rsp_err;
    logic [CMD_WIDTH-1:0]       uart_cmd;
    logic                       uart_cmd_vld;
    logic                       uart_cmd_rdy;
    logic                       uart_read_rdy;
    logic [READ_WIDTH-1:0]      uart_read_data;
    logic                       busy;
    logic [ID_W-1:0]            grant_id;

    modport master (
        output req_cmd, req_vld, uart_cmd_rdy, uart_read_rdy, uart_read_data,
        input  req_rdy, rsp_vld, rsp_data, rsp_err, uart_cmd, uart_cmd_vld, busy, grant_id
    );

    modport slave (
        input  req_cmd, req_vld, uart_cmd_rdy, uart_read_rdy, uart_read_data,
        output req_rdy, rsp_vld, rsp_data, rsp_err, uart_cmd, uart_cmd_vld, busy, grant_id
    );

endinterface

// File: rtl/uart_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after i_last, wrapping.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_gnt_onehot_c,
    output logic [IW-1:0] o_gnt_idx_c
);

    logic          w_found;
    logic [IW-1:0] w_idx;

    always_comb begin
        o_gnt_onehot_c = '0;
        o_gnt_idx_c    = '0;
        w_found        = 1'b0;
        w_idx          = '0;
        for (int k = 1; k <= int'(N); k++) begin
            w_idx = IW'((int'(i_last) + k) % int'(N));
            if (!w_found && i_req[w_idx]) begin
                w_found                = 1'b1;
                o_gnt_idx_c            = w_idx;
                o_gnt_onehot_c[w_idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_arbiter.sv
// Shares one UART command controller among N_REQ requesters: round-robin grant,
// command issue, completion/timeout tracking and response routing.
module uart_cmd_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned CMD_WIDTH  = UART_CMD_WIDTH,
    parameter int unsigned READ_WIDTH = UART_READ_WIDTH,
    parameter int unsigned TIMEOUT    = 60000
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_cmd_arbiter_if.slave bus
);

    localparam int unsigned ID_W   = $clog2(N_REQ);
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned WR_BIT = CMD_WIDTH - 1;
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    logic [1:0]            r_state,     w_state_nxt;
    logic [ID_W-1:0]       r_last,      w_last_nxt;
    logic [ID_W-1:0]       r_grant_id,  w_grant_id_nxt;
    logic [CMD_WIDTH-1:0]  r_cmd_q,     w_cmd_q_nxt;
    logic                  r_cmd_vld,   w_cmd_vld_nxt;
    logic                  r_busy,      w_busy_nxt;
    logic [CNT_W-1:0]      r_cnt,       w_cnt_nxt;
    logic                  r_seen_busy, w_seen_busy_nxt;
    logic [N_REQ-1:0]      r_rsp_vld,   w_rsp_vld_nxt;
    logic [READ_WIDTH-1:0] r_rsp_data,  w_rsp_data_nxt;
    logic                  r_rsp_err,   w_rsp_err_nxt;

    logic [N_REQ-1:0]      w_gnt_onehot;
    logic [ID_W-1:0]       w_gnt_idx;
    logic [CMD_WIDTH-1:0]  w_cmd_arr [N_REQ];
    logic                  w_done_rd;
    logic                  w_done_wr;
    logic                  w_timeout;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .i_req          (bus.req_vld),
        .i_last         (r_last),
        .o_gnt_onehot_c (w_gnt_onehot),
        .o_gnt_idx_c    (w_gnt_idx)
    );

    for (genvar g = 0; g < int'(N_REQ); g++) begin : g_slice
        assign w_cmd_arr[g] = bus.req_cmd[g*CMD_WIDTH +: CMD_WIDTH];
    end

    // A write completes once the UART has been seen busy and returns to ready.
    assign w_done_rd = !r_cmd_q[WR_BIT] && bus.uart_read_rdy;
    assign w_done_wr =  r_cmd_q[WR_BIT] && r_seen_busy && bus.uart_cmd_rdy;
    assign w_timeout = (r_cnt >= CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_last      <= ID_W'(N_REQ - 1);
            r_grant_id  <= '0;
            r_cmd_q     <= '0;
            r_cmd_vld   <= 1'b0;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
            r_seen_busy <= 1'b0;
            r_rsp_vld   <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_last      <= w_last_nxt;
            r_grant_id  <= w_grant_id_nxt;
            r_cmd_q     <= w_cmd_q_nxt;
            r_cmd_vld   <= w_cmd_vld_nxt;
            r_busy      <= w_busy_nxt;
            r_cnt       <= w_cnt_nxt;
            r_seen_busy <= w_seen_busy_nxt;
            r_rsp_vld   <= w_rsp_vld_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_last_nxt      = r_last;
        w_grant_id_nxt  = r_grant_id;
        w_cmd_q_nxt     = r_cmd_q;
        w_cnt_nxt       = r_cnt;
        w_seen_busy_nxt = r_seen_busy;
        w_rsp_vld_nxt   = '0;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_err_nxt   = r_rsp_err;
        case (r_state)
            IDLE: begin
                if (|bus.req_vld) begin
                    w_state_nxt    = ISSUE;
                    w_cmd_q_nxt    = w_cmd_arr[w_gnt_idx];
                    w_grant_id_nxt = w_gnt_idx;
                    w_last_nxt     = w_gnt_idx;
                end
            end
            ISSUE: begin
                if (r_cmd_vld && bus.uart_cmd_rdy) begin
                    w_state_nxt     = WAIT_DONE;
                    w_cnt_nxt       = '0;
                    w_seen_busy_nxt = 1'b0;
                end
            end
            WAIT_DONE: begin
                if (r_cnt != CNT_W'(TIMEOUT)) w_cnt_nxt = r_cnt + CNT_W'(1);
                if (!bus.uart_cmd_rdy) w_seen_busy_nxt = 1'b1;
                // Completion takes priority over a timeout in the same cycle.
                if (w_done_rd || w_done_wr || w_timeout) begin
                    w_state_nxt    = RESP;
                    w_rsp_vld_nxt  = ONE_HOT0 << r_grant_id;
                    w_rsp_data_nxt = w_done_rd ? bus.uart_read_data : '0;
                    w_rsp_err_nxt  = !(w_done_rd || w_done_wr);
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        w_cmd_vld_nxt = (w_state_nxt == ISSUE);
        w_busy_nxt    = (w_state_nxt != IDLE);
    end

    assign bus.req_rdy      = (rst_n && r_state == IDLE) ? w_gnt_onehot : '0;
    assign bus.rsp_vld      = r_rsp_vld;
    assign bus.rsp_data     = r_rsp_data;
    assign bus.rsp_err      = r_rsp_err;
    assign bus.uart_cmd     = r_cmd_q;
    assign bus.uart_cmd_vld = r_cmd_vld;
    assign bus.busy         = r_busy;
    assign bus.grant_id     = r_grant_id;

endmodule
